// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, default width and next-PC source selects for pc_sequencer
package pc_seq_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_e;
  typedef enum logic [2:0] {
    SRC_RESET  = 3'd0,
    SRC_SEQ    = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_JUMP   = 3'd3,
    SRC_HOLD   = 3'd4
  } pc_src_e;
endpackage

// File: rtl/pc_stall_watchdog.sv
// pc_stall_watchdog: 8-bit saturating count of consecutive stall cycles; expires on the STALL_MAX-th stall
module pc_stall_watchdog #(
  parameter int STALL_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  // clear wins over increment; saturate at 255 instead of wrapping
  always_comb cnt_d = clr_i ? 8'd0 : inc_i ? ((&cnt_q) ? cnt_q : cnt_q + 8'd1) : cnt_q;
  // counter register, async active-low reset
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign expired_o = inc_i && (cnt_q == 8'(STALL_MAX - 1));
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with run/halt sequencing and stall watchdog.
// Optional PC_SEQ_ALIGN_CHK_EN: misaligned branch/jump targets halt the core instead of being truncated.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              INC       = 4,
  parameter int              STALL_MAX = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            hazard_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic [XLEN-1:0] pc_cur_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_we_o,
  output logic            ifid_flush_o,
  output logic            ifid_stall_o,
  output logic            stall_err_o,
  output logic            run_o
);
  state_e          state_q, state_d;
  pc_src_e         src;
  logic            inc, expired, bad_br, bad_jp, active;
  logic [XLEN-1:0] br_tgt, jp_tgt;

  assign br_tgt = {branch_target_i[XLEN-1:2], 2'b00};
  assign jp_tgt = {jump_target_i[XLEN-1:2], 2'b00};
`ifdef PC_SEQ_ALIGN_CHK_EN
  assign bad_br = |branch_target_i[1:0];
  assign bad_jp = |jump_target_i[1:0];
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^{branch_target_i[1:0], jump_target_i[1:0]};
  assign bad_br = 1'b0;
  assign bad_jp = 1'b0;
`endif

  assign active = (state_q == RUN) || (state_q == REDIRECT);

  pc_stall_watchdog #(.STALL_MAX(STALL_MAX)) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (inc),
    .clr_i    (!inc),
    .expired_o(expired)
  );

  // state register, async active-low reset back to IDLE
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;

  // next state: redirects win over hazards; a bad target or expired watchdog halts for good
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = start_i ? RUN : IDLE;
      RUN, REDIRECT: begin
        if (!start_i) state_d = IDLE;
        else if (branch_taken_i) state_d = bad_br ? HALT : REDIRECT;
        else if (jump_i) state_d = bad_jp ? HALT : REDIRECT;
        else if (expired) state_d = HALT;
        else state_d = RUN;
      end
      default:      state_d = HALT;
    endcase
  end

  // outputs: PC source and IF/ID control; hazards are ignored in REDIRECT since ID holds a bubble
  always_comb begin
    src          = state_q == HALT ? SRC_HOLD : SRC_RESET;
    pc_we_o      = 1'b0;
    ifid_flush_o = 1'b0;
    ifid_stall_o = 1'b0;
    inc          = 1'b0;
    if (active) begin
      if (!start_i) src = SRC_HOLD;
      else if (branch_taken_i) begin
        src          = SRC_BRANCH;
        pc_we_o      = !bad_br;
        ifid_flush_o = 1'b1;
      end else if (jump_i) begin
        src          = SRC_JUMP;
        pc_we_o      = !bad_jp;
        ifid_flush_o = 1'b1;
      end else if (hazard_i && state_q == RUN) begin
        src          = SRC_HOLD;
        ifid_stall_o = 1'b1;
        inc          = 1'b1;
      end else begin
        src     = SRC_SEQ;
        pc_we_o = 1'b1;
      end
    end
  end

  assign pc_next_o   = src == SRC_BRANCH ? br_tgt :
                       src == SRC_JUMP   ? jp_tgt :
                       src == SRC_SEQ    ? pc_cur_i + XLEN'(INC) :
                       src == SRC_HOLD   ? pc_cur_i : RESET_PC;
  assign stall_err_o = state_q == HALT;
  assign run_o       = active;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0, hazard_i = 1'b0, branch_taken_i = 1'b0, jump_i = 1'b0;
  logic [31:0] branch_target_i = '0, jump_target_i = '0, pc_cur_i = '0;
  logic [31:0] pc_next_o;
  logic        pc_we_o, ifid_flush_o, ifid_stall_o, stall_err_o, run_o;
  int          checks = 0, errors = 0;

  pc_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .hazard_i       (hazard_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .pc_cur_i       (pc_cur_i),
    .pc_next_o      (pc_next_o),
    .pc_we_o        (pc_we_o),
    .ifid_flush_o   (ifid_flush_o),
    .ifid_stall_o   (ifid_stall_o),
    .stall_err_o    (stall_err_o),
    .run_o          (run_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b0;
    start_i = 1'b0; hazard_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    settle();
    rst_i = 1'b1;
    settle();
  endtask

  initial begin
    logic [31:0] pc;
    // reset state, start already high must not matter while in reset
    start_i = 1'b1;
    settle();
    check("rst_pc", pc_next_o, 32'h0);
    check("rst_ctl", {pc_we_o, ifid_flush_o, ifid_stall_o, stall_err_o, run_o}, 32'h0);
    tick();
    check("rst_held_run", run_o, 1'b0);
    rst_i = 1'b1;
    settle();
    check("idle_we", pc_we_o, 1'b0);
    tick();
    // 1: sequential fetch with pc_cur tracking pc_next
    pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      pc_cur_i = pc;
      settle();
      check("seq_pc", pc_next_o, pc + 32'h4);
      check("seq_we", pc_we_o, 1'b1);
      pc = pc + 32'h4;
      tick();
    end
    // 2: branch then REDIRECT ignores hazard
    pc_cur_i = 32'h10; branch_taken_i = 1'b1; branch_target_i = 32'h40;
    settle();
    check("br_pc", pc_next_o, 32'h40);
    check("br_flush_we", {ifid_flush_o, pc_we_o, ifid_stall_o}, 3'b110);
    tick();
    branch_taken_i = 1'b0; hazard_i = 1'b1; pc_cur_i = 32'h40;
    settle();
    check("redir_pc", pc_next_o, 32'h44);
    check("redir_ctl", {pc_we_o, ifid_stall_o, ifid_flush_o, run_o}, 4'b1001);
    tick();
    // 3: branch+jump+hazard together -> branch wins
    branch_taken_i = 1'b1; jump_i = 1'b1; hazard_i = 1'b1;
    branch_target_i = 32'h80; jump_target_i = 32'hC0; pc_cur_i = 32'h44;
    settle();
    check("prio_pc", pc_next_o, 32'h80);
    check("prio_ctl", {ifid_stall_o, ifid_flush_o, pc_we_o}, 3'b011);
    tick();
    branch_taken_i = 1'b0; hazard_i = 1'b0; jump_target_i = 32'h200; pc_cur_i = 32'h80;
    settle();
    check("jmp_pc", pc_next_o, 32'h200);
    tick();
    jump_i = 1'b0; pc_cur_i = 32'h200;
    settle();
    check("after_jmp_pc", pc_next_o, 32'h204);
    tick();
    // start low in RUN holds PC and drops to IDLE
    start_i = 1'b0;
    settle();
    check("stop_we", {pc_we_o, ifid_flush_o, ifid_stall_o}, 3'b000);
    tick();
    check("stop_idle", run_o, 1'b0);
    start_i = 1'b1;
    tick();
    // 14 stalls then release: no halt, counter cleared
    pc_cur_i = 32'h100;
    for (int r = 0; r < 2; r++) begin
      hazard_i = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      check("st14_err", stall_err_o, 1'b0);
      check("st14_stall", ifid_stall_o, 1'b1);
      hazard_i = 1'b0;
      settle();
      check("st14_rel_we", pc_we_o, 1'b1);
      tick();
    end
    // 4: 15 consecutive stalls -> HALT
    hazard_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      settle();
      check("wd_ctl", {pc_we_o, ifid_stall_o, stall_err_o}, 3'b010);
      tick();
    end
    check("halt_err", stall_err_o, 1'b1);
    check("halt_ctl", {pc_we_o, ifid_flush_o, ifid_stall_o, run_o}, 4'b0000);
    hazard_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_i = i[0];
      tick();
    end
    start_i = 1'b1;
    settle();
    check("halt_sticky", {stall_err_o, pc_we_o, run_o}, 3'b100);
    // 5: wrap-around, then reset mid-REDIRECT
    do_reset();
    check("rst2_err", stall_err_o, 1'b0);
    start_i = 1'b1;
    tick();
    pc_cur_i = 32'hFFFF_FFFC;
    settle();
    check("wrap_pc", pc_next_o, 32'h0);
    check("wrap_err", {pc_we_o, stall_err_o}, 2'b10);
    branch_taken_i = 1'b1; branch_target_i = 32'h40;
    tick();
    check("pre_rst_redir", {run_o, ifid_flush_o}, 2'b11);
    rst_i = 1'b0;
    settle();
    check("mid_rst_pc", pc_next_o, 32'h0);
    check("mid_rst_ctl", {pc_we_o, ifid_flush_o, ifid_stall_o, stall_err_o, run_o}, 5'b0);
    rst_i = 1'b1;
    branch_taken_i = 1'b0;
    settle();
    check("post_rst_idle", run_o, 1'b0);
    tick();
    // 6: misaligned target 0x42
    branch_taken_i = 1'b1; branch_target_i = 32'h42; pc_cur_i = 32'h8;
    settle();
`ifdef PC_SEQ_ALIGN_CHK_EN
    check("mis_ctl", {pc_we_o, ifid_flush_o}, 2'b01);
    tick();
    check("mis_err", stall_err_o, 1'b1);
`else
    check("mis_pc", pc_next_o, 32'h40);
    check("mis_ctl", {pc_we_o, ifid_flush_o}, 2'b11);
    tick();
    check("mis_err", stall_err_o, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
